uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
UART transmit stage that drives the CPU's serial output pin `uart_tx`. The CPU store path writes bytes into an internal FIFO. An FSM serialises them as 8N1 frames at a fixed baud rate. It sits between the CPU's memory-mapped I/O write port and the top-level `uart_tx` pin.

Parameters:
- CLK_FREQ, 100000000, sysclk frequency in Hz.
- BAUD, 115200, line rate; CLKS_PER_BIT = CLK_FREQ / BAUD, integer-truncated (868 at defaults); must be ≥ 2.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries (16).

Ports:
- sysclk  in  1  system clock; all logic on the rising edge.
- cpu_reset  in  1  synchronous, active-high reset.
- wr_en  in  1  push request from the CPU I/O write.
- wr_data  in  8  byte to transmit.
- full  out  1  FIFO full; a push while full is dropped.
- busy  out  1  high when the FIFO is non-empty or a frame is in progress.
- fifo_count  out  FIFO_AW+1  number of entries currently in the FIFO.
- uart_tx  out  1  serial line; idle high.

Behaviour:
- Reset (cpu_reset sampled high):
  - uart_tx=1, full=0, busy=0, fifo_count=0.
  - FSM goes to IDLE; baud counter and bit index clear.
  - Any frame in flight is aborted immediately; the line returns high on the next edge.
- FIFO:
  - Push when wr_en && !full. full is derived from the registered count (count == depth).
  - Pop only by the FSM.
  - Push and pop in the same cycle: count unchanged, data order preserved.
  - Read/write pointers wrap modulo depth.
  - A push while full is ignored silently; FIFO contents are unchanged.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, set uart_tx=0, go to START.
  - START: hold for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: drive shreg[idx], LSB first, each bit for CLKS_PER_BIT cycles. After bit 7, go to STOP (or PARITY when the optional feature is enabled).
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. At the end: if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and reloads at every state/bit change.
  - Width is clog2(CLKS_PER_BIT).
- Latency: wr_en sampled at edge k into an empty FIFO while IDLE → uart_tx low after edge k+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles (11× with parity).
- uart_tx is driven from a register, with no combinational path to the pin.
- busy = (state != IDLE) || (fifo_count != 0).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
  - Defined: adds a PARITY state between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame = 11 bit-times.
  - Undefined: the PARITY state and its logic are absent. Frame = 10 bit-times, 8N1.

Decomposition:
- Shared package/define file holds:
  - State encodings: TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP.
  - Constant/function computing CLKS_PER_BIT.
  - The UART_TX_PARITY_EN macro default, in the project define file.
- One natural sub-module: sync_fifo.
  - Parameterised width=8 and FIFO_AW.
  - Ports: push/pop/din/dout/full/empty/count.
  - Same synchronous active-high reset.

Test Plan (CLK_FREQ=1000, BAUD=100 → 10 cycles/bit):
- Reset, then idle for 50 cycles → uart_tx=1, busy=0, fifo_count=0 throughout.
- Single write 0x55 →
  - uart_tx falls 2 edges after the write.
  - Line shows 0,1,0,1,0,1,0,1,0,1, each 10 cycles wide.
  - busy drops after cycle 100.
- Three back-to-back writes 0x41,0x42,0x43 → three contiguous frames, 300 cycles total, with no high gap between stop and the next start bit.
- 20 writes in 20 consecutive cycles (depth 16) →
  - full asserts once 16 entries are queued; fifo_count peaks at 16.
  - Writes that hit full are dropped.
  - Exactly 17 frames are transmitted: 1 popped early plus 16 queued.
- cpu_reset asserted mid-DATA of 0xA5 →
  - uart_tx=1 on the next edge; fifo_count=0.
  - No further frames; a fresh write afterwards transmits correctly.
- With UART_TX_PARITY_EN defined, write 0x07 → 11-bit frame: data bits LSB-first 1,1,1,0,0,0,0,0, parity=1, then stop.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit stage: FSM encodings and baud divisor helper.
// UART_TX_PARITY_EN is left undefined by default (plain 8N1); define it to add an even-parity bit.
package uart_tx_fifo_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    // Integer-truncated divisor; callers must keep the result >= 2.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; head word is visible on dout
// whenever the FIFO is non-empty (show-ahead).
module sync_fifo #(
    parameter int WIDTH   = 8,
    parameter int FIFO_AW = 4
) (
    input  logic               sysclk,
    input  logic               cpu_reset,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == (FIFO_AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; entries are only observable after a push,
    // and leaving the array reset-free lets it map onto plain RAM.
    always_ff @(posedge sysclk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly FIFO_AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge sysclk) begin
        if (cpu_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit stage: CPU writes bytes into a FIFO, an FSM serialises them LSB first.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200,
    parameter int FIFO_AW  = 4
) (
    input  logic               sysclk,
    input  logic               cpu_reset,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    output logic               full,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               uart_tx
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_done;
    logic             fifo_pop;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;

    assign bit_done = (baud_cnt == CNT_LAST);
    // Pop on the same edge the FSM latches the head, so back-to-back frames need no idle gap.
    assign fifo_pop = !fifo_empty && ((state == TX_IDLE) || (state == TX_STOP && bit_done));
    assign busy     = (state != TX_IDLE) || (fifo_count != '0);

    sync_fifo #(
        .WIDTH   (8),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .sysclk    (sysclk),
        .cpu_reset (cpu_reset),
        .push      (wr_en),
        .pop       (fifo_pop),
        .din       (wr_data),
        .dout      (fifo_dout),
        .full      (full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // NOTE: every register below uses non-blocking assignment so all next-state values
    // are computed from the pre-edge state, regardless of statement order.
    always_ff @(posedge sysclk) begin
        if (cpu_reset) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            uart_tx  <= 1'b1;
        end else begin
            case (state)
                TX_IDLE: begin
                    baud_cnt <= '0;
                    if (!fifo_empty) begin
                        shreg   <= fifo_dout;
                        uart_tx <= 1'b0;
                        state   <= TX_START;
                    end
                end
                TX_START: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        uart_tx  <= shreg[0];
                        state    <= TX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            uart_tx <= ^shreg;
                            state   <= TX_PARITY;
`else
                            uart_tx <= 1'b1;
                            state   <= TX_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= shreg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                TX_PARITY: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        uart_tx  <= 1'b1;
                        state    <= TX_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                TX_STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (!fifo_empty) begin
                            shreg   <= fifo_dout;
                            uart_tx <= 1'b0;
                            state   <= TX_START;
                        end else begin
                            state   <= TX_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    baud_cnt <= '0;
                    uart_tx  <= 1'b1;
                    state    <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a line monitor decodes frames and compares them
// against a queue of bytes pushed when writes are driven.
module tb_uart_tx_fifo;

    localparam int CPB     = 10;
    localparam int FIFO_AW = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS   = 11;
`else
    localparam int NBITS   = 10;
`endif
    localparam int FRAME   = NBITS * CPB;

    logic             sysclk;
    logic             cpu_reset;
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             full;
    logic             busy;
    logic [FIFO_AW:0] fifo_count;
    logic             uart_tx;

    int               n_tests;
    int               n_fail;
    int               cyc;
    int               frames_seen;
    logic [7:0]       exp_q[$];
    int               start_cyc[$];

    logic [NBITS-1:0] m_bits;
    bit               m_stable;
    bit               m_aborted;
    logic [7:0]       m_exp;

    uart_tx_fifo #(
        .CLK_FREQ (1000),
        .BAUD     (100),
        .FIFO_AW  (FIFO_AW)
    ) dut (
        .sysclk     (sysclk),
        .cpu_reset  (cpu_reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .busy       (busy),
        .fifo_count (fifo_count),
        .uart_tx    (uart_tx)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    initial cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1 with wr_en low.
    task automatic do_write(input logic [7:0] b, input bit accept);
        wr_en   = 1'b1;
        wr_data = b;
        if (accept) exp_q.push_back(b);
        @(posedge sysclk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge sysclk);
            n++;
        end while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget);
        check({tag, "_drained"}, 32'(n < budget), 1);
        @(posedge sysclk);
        #1;
    endtask

    // Line monitor: samples every cycle of a frame, requiring each bit slot to be constant.
    initial begin
        frames_seen = 0;
        forever begin
            @(negedge sysclk);
            if (cpu_reset === 1'b0 && uart_tx === 1'b0) begin
                start_cyc.push_back(cyc);
                m_bits    = '0;
                m_stable  = 1'b1;
                m_aborted = 1'b0;
                for (int s = 0; s < NBITS && !m_aborted; s++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (s != 0 || c != 0) @(negedge sysclk);
                        if (cpu_reset !== 1'b0) begin
                            m_aborted = 1'b1;
                            break;
                        end
                        if (c == 0) m_bits[s] = uart_tx;
                        else if (uart_tx !== m_bits[s]) m_stable = 1'b0;
                    end
                end
                if (!m_aborted) begin
                    check("bit_width", 32'(m_stable), 1);
                    check("frame_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        m_exp = exp_q.pop_front();
                        check("start_bit", 32'(m_bits[0]), 0);
                        check("data_bits", 32'(m_bits[8:1]), 32'(m_exp));
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", 32'(m_bits[9]), 32'(^m_exp));
`endif
                        check("stop_bit", 32'(m_bits[NBITS-1]), 1);
                        frames_seen++;
                    end
                end
            end
        end
    end

    initial begin
        int base_frames;
        int base_starts;
        int exp_cnt;
        int lows;

        n_tests   = 0;
        n_fail    = 0;
        cpu_reset = 1'b1;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        repeat (3) @(posedge sysclk);
        #1;
        cpu_reset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 50; i++) begin
            @(negedge sysclk);
            check("idle_tx", 32'(uart_tx), 1);
            check("idle_busy", 32'(busy), 0);
            check("idle_count", 32'(fifo_count), 0);
            check("idle_full", 32'(full), 0);
        end
        @(posedge sysclk);
        #1;

        // Single byte: latency, frame shape, busy release.
        base_frames = frames_seen;
        do_write(8'h55, 1'b1);
        @(negedge sysclk);
        check("lat_edge_k", 32'(uart_tx), 1);
        @(negedge sysclk);
        check("lat_edge_k1", 32'(uart_tx), 0);
        repeat (FRAME - 1) @(negedge sysclk);
        check("busy_last_cycle", 32'(busy), 1);
        @(negedge sysclk);
        check("busy_released", 32'(busy), 0);
        check("line_idle_after", 32'(uart_tx), 1);
        wait_idle(200, "single");
        check("single_frames", 32'(frames_seen - base_frames), 1);

        // Three back-to-back bytes must produce contiguous frames.
        base_frames = frames_seen;
        base_starts = start_cyc.size();
        do_write(8'h41, 1'b1);
        do_write(8'h42, 1'b1);
        do_write(8'h43, 1'b1);
        wait_idle(3 * FRAME + 50, "b2b");
        check("b2b_frames", 32'(frames_seen - base_frames), 3);
        if (start_cyc.size() == base_starts + 3) begin
            check("b2b_gap01", 32'(start_cyc[base_starts+1] - start_cyc[base_starts]), FRAME);
            check("b2b_gap12", 32'(start_cyc[base_starts+2] - start_cyc[base_starts+1]), FRAME);
        end else begin
            check("b2b_starts", 32'(start_cyc.size() - base_starts), 3);
        end

        // Burst of 20: one entry leaves at the second edge, the rest fill to 16 and overflow.
        base_frames = frames_seen;
        for (int j = 0; j < 20; j++) begin
            do_write(8'h10 + 8'(j), j <= 16);
            exp_cnt = (j == 0) ? 1 : ((j < 16) ? j : 16);
            check("burst_count", 32'(fifo_count), 32'(exp_cnt));
            check("burst_full", 32'(full), 32'(exp_cnt == 16));
        end
        wait_idle(17 * FRAME + 100, "burst");
        check("burst_frames", 32'(frames_seen - base_frames), 17);
        check("burst_count_end", 32'(fifo_count), 0);

        // Reset in the middle of a data bit with a second byte still queued.
        base_frames = frames_seen;
        do_write(8'hA5, 1'b1);
        do_write(8'h3C, 1'b1);
        repeat (40) @(posedge sysclk);
        #1;
        check("pre_reset_busy", 32'(busy), 1);
        cpu_reset = 1'b1;
        exp_q.delete();
        @(posedge sysclk);
        #1;
        check("reset_tx", 32'(uart_tx), 1);
        check("reset_count", 32'(fifo_count), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_full", 32'(full), 0);
        cpu_reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge sysclk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("post_reset_quiet", 32'(lows), 0);
        check("post_reset_frames", 32'(frames_seen - base_frames), 0);
        @(posedge sysclk);
        #1;
        do_write(8'h96, 1'b1);
        wait_idle(FRAME + 50, "post_reset");
        check("post_reset_new", 32'(frames_seen - base_frames), 1);

        // 0x07: under the parity build the monitor also checks parity=1.
        base_frames = frames_seen;
        do_write(8'h07, 1'b1);
        wait_idle(FRAME + 50, "parity");
        check("parity_frames", 32'(frames_seen - base_frames), 1);
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
